// File: rtl/mem_arb2.sv
// rtl/mem_arb2.sv - two-master round-robin arbiter onto a single SRAM port
// Optional WAIT-state timeout is enabled by defining ARB_TIMEOUT_EN.
module mem_arb2 #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        busy,
    output logic        grant_id,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_grant;
    logic        r_last;
    logic        r_instr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic        w_req;
    logic        w_pick;
    logic        w_timeout;
    logic        w_done;
    logic [31:0] w_resp_data;

    assign w_req  = m0_valid | m1_valid;
    // On a tie the master that did not win last time goes next.
    assign w_pick = (m0_valid && m1_valid) ? ~r_last : m1_valid;
    assign w_done = (r_state == WAIT) && (s_ready || w_timeout);
    assign w_resp_data = s_ready ? s_rdata : ERR_RDATA;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_terr;

    // s_ready on the limit cycle wins, so the timeout is qualified by !s_ready.
    assign w_timeout = (r_state == WAIT) && !s_ready &&
                       (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_terr <= 1'b0;
        end else begin
            if (r_state == ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == WAIT && !s_ready) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_timeout) begin
                r_terr <= 1'b1;
            end
        end
    end

    assign timeout_err = r_terr;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        s_valid      = 1'b0;
        m0_ready     = 1'b0;
        m1_ready     = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_req) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                s_valid      = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: begin
                if (w_done) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                m0_ready     = ~r_grant;
                m1_ready     = r_grant;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant  <= 1'b0;
            r_last   <= 1'b1;
            r_instr  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (r_state == IDLE && w_req) begin
                r_grant <= w_pick;
                r_last  <= w_pick;
                r_instr <= w_pick ? m1_instr : m0_instr;
                r_addr  <= w_pick ? m1_addr  : m0_addr;
                r_wdata <= w_pick ? m1_wdata : m0_wdata;
                r_wstrb <= w_pick ? m1_wstrb : m0_wstrb;
            end
            if (w_done) begin
                if (r_grant) begin
                    r_rdata1 <= w_resp_data;
                end else begin
                    r_rdata0 <= w_resp_data;
                end
            end
        end
    end

    assign s_instr  = r_instr;
    assign s_addr   = r_addr;
    assign s_wdata  = r_wdata;
    assign s_wstrb  = r_wstrb;
    assign grant_id = r_grant;
    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;

endmodule

// File: tb/tb_mem_arb2.sv
// tb/tb_mem_arb2.sv - self-checking bench for mem_arb2 with an in-bench SRAM model
`timescale 1ns/1ps
module tb_mem_arb2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        busy, grant_id, timeout_err;

    mem_arb2 dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // SRAM model state
    logic [31:0] mem [logic [31:0]];
    bit          sp = 0;
    int          scnt = 0;
    bit          junk = 1, rnd = 0, hang = 0;
    int          sdelay = 0;
    logic [31:0] sresp = 0;
    int          sv_cnt = 0;
    logic        lg_instr;
    logic [31:0] lg_wdata;
    logic [3:0]  lg_wstrb;
    logic [31:0] exp_r [2];

    typedef struct {
        bit          m;
        bit          ins;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          d;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // One clock: wait for the falling edge, then let the SRAM model react.
    task automatic tick();
        logic [31:0] w;
        @(negedge clk);
        if (rst) begin
            sp = 0;
            s_ready = 1'b0;
        end else if (sp) begin
            if (scnt == 0) begin
                s_ready = 1'b1;
                s_rdata = sresp;
                sp = 0;
            end else begin
                s_ready = 1'b0;
                s_rdata = $urandom;
                scnt--;
            end
        end else begin
            s_ready = junk ? 1'($urandom % 2) : 1'b0;
            s_rdata = $urandom;
        end
        if (s_valid === 1'b1 && !rst) begin
            sv_cnt++;
            lg_instr = s_instr;
            lg_wdata = s_wdata;
            lg_wstrb = s_wstrb;
            sresp = rd(s_addr);
            if (s_wstrb != 4'b0) begin
                w = sresp;
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) w[8*b +: 8] = s_wdata[8*b +: 8];
                mem[s_addr] = w;
            end
            sp = 1;
            scnt = hang ? 1000000 : (rnd ? int'($urandom_range(0, 3)) : sdelay);
        end
    endtask

    task automatic drive_m(input bit m, input bit v, input bit ins, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] ws);
        if (m) begin
            m1_valid = v; m1_instr = ins; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
        end else begin
            m0_valid = v; m0_instr = ins; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {21'b0, s_valid, s_instr, s_wstrb, m0_ready, m1_ready, busy, grant_id, timeout_err}, 32'h0);
        chk({tag, "_s_addr"}, s_addr, 32'h0);
        chk({tag, "_s_wdata"}, s_wdata, 32'h0);
        chk({tag, "_m0_rdata"}, m0_rdata, 32'h0);
        chk({tag, "_m1_rdata"}, m1_rdata, 32'h0);
    endtask

    task automatic do_txn(input bit m, input bit ins, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input int d, input logic [31:0] exp_rd);
        int lat;
        bit got;
        int sv0;
        sdelay = d;
        sv0 = sv_cnt;
        drive_m(m, 1'b1, ins, a, wd, ws);
        lat = 0;
        got = 0;
        while (!got && lat < 60) begin
            tick();
            lat++;
            chk("other_ready_low", m ? m0_ready : m1_ready, 1'b0);
            if ((m ? m1_ready : m0_ready) === 1'b1) got = 1;
        end
        chk("txn_done", got, 1'b1);
        chk("latency", lat, 3 + d);
        chk("rdata", m ? m1_rdata : m0_rdata, exp_rd);
        chk("grant_id", grant_id, m);
        chk("issue_once", sv_cnt - sv0, 1);
        chk("s_addr_hold", s_addr, a);
        chk("s_wdata", lg_wdata, wd);
        chk("s_wstrb", lg_wstrb, ws);
        chk("s_instr", lg_instr, ins);
        exp_r[m] = exp_rd;
        chk("other_rdata_hold", m ? m0_rdata : m1_rdata, exp_r[!m]);
        drive_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
    endtask

    initial begin
        bit          act [2];
        bit          iss [2];
        bit          pi [2];
        logic [31:0] pa [2];
        logic [31:0] pw [2];
        logic [3:0]  ps [2];
        logic [31:0] er [2];
        bit          lastg;
        bit          w;
        bit          got;
        int          done;
        int          n;

        tbl[0] = '{0, 0, 32'h10, 32'h0,         4'b0000, 0, 32'h1234_5678};
        tbl[1] = '{1, 0, 32'h20, 32'hAABB_CCDD, 4'b0011, 0, 32'h1122_3344};
        tbl[2] = '{1, 0, 32'h20, 32'h0,         4'b0000, 1, 32'h1122_CCDD};
        tbl[3] = '{0, 0, 32'h30, 32'hCAFE_F00D, 4'b1111, 2, 32'h0};
        tbl[4] = '{0, 1, 32'h30, 32'h0,         4'b0000, 3, 32'hCAFE_F00D};
        tbl[5] = '{1, 0, 32'h40, 32'hA5B6_C7D8, 4'b1000, 0, 32'h0102_0304};
        tbl[6] = '{1, 1, 32'h40, 32'h0,         4'b0000, 0, 32'hA502_0304};
        mem[32'h10] = 32'h1234_5678;
        mem[32'h20] = 32'h1122_3344;
        mem[32'h40] = 32'h0102_0304;

        rst = 1'b1;
        s_ready = 1'b0;
        s_rdata = 32'h0;
        drive_m(0, 0, 0, 0, 0, 0);
        drive_m(1, 0, 0, 0, 0, 0);
        exp_r[0] = 0;
        exp_r[1] = 0;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++)
            do_txn(tbl[i].m, tbl[i].ins, tbl[i].a, tbl[i].wd, tbl[i].ws, tbl[i].d, tbl[i].exp);

        // Reset in the middle of WAIT
        hang = 1;
        drive_m(0, 1, 0, 32'h30, 0, 0);
        repeat (3) tick();
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1;
        drive_m(0, 0, 0, 0, 0, 0);
        tick();
        chk_reset("mid_rst");
        rst = 1'b0;
        hang = 0;
        exp_r[0] = 0;
        exp_r[1] = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_no_ready", {m0_ready, m1_ready, busy}, 3'b000);
        end

        // Both masters held: grants alternate starting with m0
        sdelay = 0;
        drive_m(0, 1, 0, 32'h10, 0, 0);
        drive_m(1, 1, 0, 32'h20, 0, 0);
        for (int i = 0; i < 4; i++) begin
            got = 0;
            n = 0;
            while (!got && n < 20) begin
                tick();
                n++;
                if (m0_ready === 1'b1 || m1_ready === 1'b1) got = 1;
            end
            chk("rr_done", got, 1'b1);
            chk("rr_order", {m1_ready, m0_ready}, (i % 2) ? 2'b10 : 2'b01);
            chk("rr_grant_id", grant_id, i % 2);
        end
        drive_m(0, 0, 0, 0, 0, 0);
        drive_m(1, 0, 0, 0, 0, 0);
        tick();
        exp_r[0] = 32'h1234_5678;
        exp_r[1] = 32'h1122_CCDD;
        chk("rr_m0_data", m0_rdata, exp_r[0]);
        chk("rr_m1_data", m1_rdata, exp_r[1]);

`ifdef ARB_TIMEOUT_EN
        do_txn(0, 0, 32'h10, 0, 0, 14, 32'h1234_5678);
        chk("to_below_limit_err", timeout_err, 1'b0);
        do_txn(0, 0, 32'h10, 0, 0, 15, 32'h1234_5678);
        chk("to_limit_ready_wins", timeout_err, 1'b0);
        hang = 1;
        do_txn(0, 0, 32'h10, 0, 0, 15, 32'hDEAD_BEEF);
        hang = 0;
        sp = 0;
        chk("to_err_set", timeout_err, 1'b1);
        do_txn(1, 0, 32'h20, 0, 0, 0, 32'h1122_CCDD);
        chk("to_err_sticky", timeout_err, 1'b1);
`else
        hang = 1;
        drive_m(0, 1, 0, 32'h10, 0, 0);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("long_wait_no_ready", {m0_ready, m1_ready}, 2'b00);
        end
        chk("long_wait_busy", busy, 1'b1);
        chk("long_wait_no_err", timeout_err, 1'b0);
        hang = 0;
        scnt = 0;
        got = 0;
        n = 0;
        while (!got && n < 5) begin
            tick();
            n++;
            if (m0_ready === 1'b1) got = 1;
        end
        chk("long_wait_done", got, 1'b1);
        chk("long_wait_rdata", m0_rdata, 32'h1234_5678);
        drive_m(0, 0, 0, 0, 0, 0);
        tick();
`endif

        // Randomised traffic from both masters against a transaction-level model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lastg = 1;
        rnd = 1;
        junk = 1;
        done = 0;
        for (int m = 0; m < 2; m++) begin
            act[m] = 0;
            iss[m] = 0;
        end
        for (int cyc = 0; cyc < 700; cyc++) begin
            tick();
            if (s_valid === 1'b1) begin
                chk("rnd_has_req", m0_valid | m1_valid, 1'b1);
                w = (m0_valid && m1_valid) ? !lastg : m1_valid;
                chk("rnd_grant", grant_id, w);
                chk("rnd_addr", s_addr, pa[w]);
                chk("rnd_wdata", s_wdata, pw[w]);
                chk("rnd_wstrb", s_wstrb, ps[w]);
                chk("rnd_instr", s_instr, pi[w]);
                chk("rnd_issue_once", iss[w], 1'b0);
                iss[w] = 1;
                er[w] = sresp;
                lastg = w;
            end
            for (int m = 0; m < 2; m++) begin
                if ((m ? m1_ready : m0_ready) === 1'b1) begin
                    chk("rnd_ready_issued", iss[m], 1'b1);
                    chk("rnd_rdata", m ? m1_rdata : m0_rdata, er[m]);
                    chk("rnd_hold", s_addr, pa[m]);
                    act[m] = 0;
                    iss[m] = 0;
                    done++;
                    drive_m(m[0], 0, 0, 0, 0, 0);
                end
            end
            if (cyc < 500) begin
                for (int m = 0; m < 2; m++) begin
                    if (!act[m] && ($urandom % 3) == 0) begin
                        act[m] = 1;
                        pi[m] = 1'($urandom % 2);
                        pa[m] = 32'h100 + 4 * $urandom_range(0, 7);
                        pw[m] = $urandom;
                        ps[m] = 4'($urandom);
                        drive_m(m[0], 1, pi[m], pa[m], pw[m], ps[m]);
                    end
                end
            end else if (!act[0] && !act[1]) begin
                break;
            end
        end
        chk("rnd_drained", {act[0], act[1]}, 2'b00);
        chk("rnd_enough_txns", done > 40, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arb2.md
MEM_ARB2 -- requirements
Module: mem_arb2

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of WAIT cycles allowed before a request is aborted.
REQ-002 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, meaning the read data returned on a timed-out request.
REQ-003 SHALL use one clock and a synchronous, active-high reset; there is no other clock or reset domain.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: the synchronous, active-high reset.
REQ-006 SHALL have master ports m0_valid/m0_instr (in, 1), m0_addr/m0_wdata (in, 32), m0_wstrb (in, 4), m0_ready (out, 1) and m0_rdata (out, 32), forming requester 0 (CPU).
REQ-007 SHALL have an identical port set m1_*, forming requester 1 (DMA/debug).
REQ-008 SHALL have ports s_valid/s_instr (out, 1), s_addr/s_wdata (out, 32), s_wstrb (out, 4), s_ready (in, 1) and s_rdata (in, 32), connecting to the SRAM port.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-010 SHALL have port grant_id, output, 1 bit: the index of the master currently owning the SRAM port.
REQ-011 SHALL have port timeout_err, output, 1 bit: a sticky timeout flag.

Function
REQ-012 SHALL implement FSM states IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-013 IDLE: when any mN_valid is high, SHALL grant a master, register that master's instr/addr/wdata/wstrb into the s_* holding registers, and go to ISSUE.
REQ-014 Arbitration SHALL be round-robin: if both masters request, grant the master not granted last; a single requester is always granted.
REQ-015 After reset, the last-granted pointer SHALL be 1, so m0 wins the first tie.
REQ-016 ISSUE: SHALL drive s_valid=1 for exactly one cycle, then go to WAIT; s_valid SHALL be 0 in every other state, so each access is issued to the SRAM exactly once.
REQ-017 s_addr/s_wdata/s_wstrb/s_instr SHALL remain stable from ISSUE through RESP.
REQ-018 WAIT: on s_ready=1, SHALL capture s_rdata into the granted master's rdata register and go to RESP.
REQ-019 RESP: SHALL drive the granted master's mN_ready=1 for exactly one cycle, then go to IDLE; the non-granted master's ready SHALL stay 0.
REQ-020 Latency from mN_valid first high in IDLE to mN_ready SHALL be 3 cycles when the SRAM answers one cycle after s_valid.
REQ-021 A master SHALL hold valid and its payload until it sees ready; inputs from a master are sampled only in IDLE.
REQ-022 Re-grant SHALL never occur in the RESP cycle; the earliest next grant is in the following IDLE cycle.
REQ-023 mN_rdata SHALL hold its last value until overwritten by that master's next completion.
REQ-024 Write requests (any wstrb bit set) SHALL return the s_rdata captured in WAIT, unmodified.
REQ-025 s_ready asserted in IDLE, ISSUE or RESP SHALL be ignored.

Reset
REQ-026 On rst=1 the block SHALL set: state=IDLE, s_valid=0, s_instr=0, s_addr=0, s_wdata=0, s_wstrb=0, m0_ready=0, m1_ready=0, m0_rdata=0, m1_rdata=0, busy=0, grant_id=0, last-grant=1, timeout counter=0, timeout_err=0.
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction; no mN_ready pulse SHALL follow.

Configuration
REQ-028 With macro ARB_TIMEOUT_EN defined, a counter SHALL clear on entering WAIT and increment each WAIT cycle without s_ready.
REQ-029 With ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL load ERR_RDATA into the granted master's rdata, set timeout_err (sticky until rst), and go to RESP.
REQ-030 With ARB_TIMEOUT_EN defined, s_ready=1 in the same cycle as the count limit SHALL take priority: real data is returned and no error is flagged.
REQ-031 Without ARB_TIMEOUT_EN, WAIT SHALL last indefinitely, no counter SHALL exist, and timeout_err SHALL be tied to 0.

Verification
REQ-032 Scenario: m0 reads addr 0x10 holding 0x1234_5678 -> s_valid one cycle, m0_ready 3 cycles after m0_valid, m0_rdata=0x1234_5678.
REQ-033 Scenario: m1 writes wdata 0xAABB_CCDD with wstrb=4'b0011 to 0x20, then reads 0x20 -> exactly one s_valid per access; readback low half = 0xCCDD.
REQ-034 Scenario: m0 and m1 request in the same cycle, both held for 4 transactions -> grants in order m0, m1, m0, m1; grant_id matches each grant.
REQ-035 Scenario: rst pulsed while in WAIT -> no mN_ready pulse follows and all outputs are at their reset values on the next cycle.
REQ-036 Scenario (ARB_TIMEOUT_EN defined): s_ready held at 0 -> after 16 WAIT cycles m0_ready=1, m0_rdata=0xDEAD_BEEF, timeout_err=1 and it stays 1.
REQ-037 Scenario (ARB_TIMEOUT_EN defined): s_ready=1 on the limit cycle -> real data is returned and timeout_err stays 0.
